// File: rtl/fifo_wm_pkg.sv
// Shared definitions for the watermark FIFO: active-low logic constants and
// width helpers used to size the level counter and the read/write pointers.
package fifo_wm_pkg;

  localparam logic nT = 1'b0;
  localparam logic nF = 1'b1;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry pointer still needs one bit to exist.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular pointer for the watermark FIFO: advances on inc and wraps from
// DEPTH-1 back to 0, so any DEPTH works, not only powers of two.
module fifo_ptr
  import fifo_wm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      n_clr,
  input  logic                      inc,
  output logic [ptr_w(DEPTH)-1:0]   ptr
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (n_clr == nT) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = (ptr_reg == PW'(DEPTH - 1)) ? '0 : ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (n_rst == nT) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_wm.sv
// First-word-fall-through FIFO with almost-empty/almost-full watermarks,
// sticky overflow/underflow flags and active-low control and status.
module fifo_wm
  import fifo_wm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 2,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      n_clr,
  input  logic                      n_wr,
  input  logic                      n_rd,
  input  logic [WIDTH-1:0]          port_in,
  output logic [WIDTH-1:0]          port_out,
  output logic                      n_empty,
  output logic                      n_full,
  output logic                      n_valid,
  output logic                      n_aempty,
  output logic                      n_afull,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      n_ovf,
  output logic                      n_udf
);

  localparam int LW = lvl_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] rp;
  logic [PW-1:0] wp;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          n_ovf_reg;
  logic          n_ovf_next;
  logic          n_udf_reg;
  logic          n_udf_next;

  logic clr;
  logic is_empty;
  logic is_full;
  logic rd_acc;
  logic wr_acc;

  assign clr      = (n_clr == nT);
  assign is_empty = (level_reg == '0);
  assign is_full  = (level_reg == LW'(DEPTH));

  // A full FIFO still takes a write when the head is popped on the same edge.
  assign rd_acc = (n_rd == nT) && !is_empty;
  assign wr_acc = (n_wr == nT) && (!is_full || rd_acc);

  // Clear overrides traffic, so the pointers must not advance either.
  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .n_clr (n_clr),
    .inc   (wr_acc),
    .ptr   (wp)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .n_clr (n_clr),
    .inc   (rd_acc),
    .ptr   (rp)
  );

  always_comb begin
    level_next = level_reg;
    n_ovf_next = n_ovf_reg;
    n_udf_next = n_udf_reg;
    if (clr) begin
      level_next = '0;
      n_ovf_next = nF;
      n_udf_next = nF;
    end else begin
      if (wr_acc && !rd_acc) begin
        level_next = level_reg + LW'(1);
      end else if (rd_acc && !wr_acc) begin
        level_next = level_reg - LW'(1);
      end
      if ((n_wr == nT) && !wr_acc) begin
        n_ovf_next = nT;
      end
      if ((n_rd == nT) && is_empty) begin
        n_udf_next = nT;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (n_rst == nT) begin
      level_reg <= '0;
      n_ovf_reg <= nF;
      n_udf_reg <= nF;
    end else begin
      level_reg <= level_next;
      n_ovf_reg <= n_ovf_next;
      n_udf_reg <= n_udf_next;
    end
  end

  // Storage holds no reset; stale words are masked by the level-based decode.
  always_ff @(posedge clk) begin
    if ((n_rst == nF) && !clr && wr_acc) begin
      mem[wp] <= port_in;
    end
  end

  assign port_out = is_empty ? '0 : mem[rp];

  assign level    = level_reg;
  assign n_empty  = is_empty ? nT : nF;
  assign n_valid  = is_empty ? nF : nT;
  assign n_full   = is_full  ? nT : nF;
  assign n_aempty = (level_reg <= LW'(AE_LEVEL)) ? nT : nF;
  assign n_afull  = (level_reg >= LW'(AF_LEVEL)) ? nT : nF;
  assign n_ovf    = n_ovf_reg;
  assign n_udf    = n_udf_reg;

endmodule

// File: tb/tb_fifo_wm.sv
// Self-checking bench for fifo_wm (WIDTH=8, DEPTH=4, AF=3, AE=1): directed
// table, hand-written corner sequences and random traffic against a queue model.
module tb_fifo_wm;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic             clk;
  logic             n_rst;
  logic             n_clr;
  logic             n_wr;
  logic             n_rd;
  logic [WIDTH-1:0] port_in;
  logic [WIDTH-1:0] port_out;
  logic             n_empty;
  logic             n_full;
  logic             n_valid;
  logic             n_aempty;
  logic             n_afull;
  logic [2:0]       level;
  logic             n_ovf;
  logic             n_udf;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue plus two "error seen" booleans.
  logic [WIDTH-1:0] q[$];
  bit ovf_seen;
  bit udf_seen;

  fifo_wm #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .n_clr    (n_clr),
    .n_wr     (n_wr),
    .n_rd     (n_rd),
    .port_in  (port_in),
    .port_out (port_out),
    .n_empty  (n_empty),
    .n_full   (n_full),
    .n_valid  (n_valid),
    .n_aempty (n_aempty),
    .n_afull  (n_afull),
    .level    (level),
    .n_ovf    (n_ovf),
    .n_udf    (n_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_seen = 1'b0;
    udf_seen = 1'b0;
  endtask

  task automatic model_edge(input bit wr, input bit rd, input bit clr, input logic [WIDTH-1:0] din);
    bit rd_ok;
    bit wr_ok;
    if (clr) begin
      model_reset();
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
      if (rd && q.size() == 0) udf_seen = 1'b1;
      if (wr && !wr_ok) ovf_seen = 1'b1;
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(din);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [WIDTH-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    chk({tag, ".level"},    {29'd0, level}, n);
    chk({tag, ".port_out"}, {24'd0, port_out}, {24'd0, head});
    chk({tag, ".n_empty"},  {31'd0, n_empty},  {31'd0, n != 0});
    chk({tag, ".n_full"},   {31'd0, n_full},   {31'd0, n != DEPTH});
    chk({tag, ".n_valid"},  {31'd0, n_valid},  {31'd0, n == 0});
    chk({tag, ".n_aempty"}, {31'd0, n_aempty}, {31'd0, !(n <= AE)});
    chk({tag, ".n_afull"},  {31'd0, n_afull},  {31'd0, !(n >= AF)});
    chk({tag, ".n_ovf"},    {31'd0, n_ovf},    {31'd0, !ovf_seen});
    chk({tag, ".n_udf"},    {31'd0, n_udf},    {31'd0, !udf_seen});
  endtask

  // One clock transaction: drive, take the edge, update model, sample 1 ns later.
  task automatic step(input string tag, input bit wr, input bit rd, input bit clr,
                      input logic [WIDTH-1:0] din);
    n_wr    = !wr;
    n_rd    = !rd;
    n_clr   = !clr;
    port_in = din;
    @(posedge clk);
    model_edge(wr, rd, clr, din);
    #1;
    $display("txn %-10s wr=%0b rd=%0b clr=%0b din=%02h -> level=%0d out=%02h ovf_n=%0b udf_n=%0b",
             tag, wr, rd, clr, din, level, port_out, n_ovf, n_udf);
    check_model(tag);
    n_wr  = 1'b1;
    n_rd  = 1'b1;
    n_clr = 1'b1;
  endtask

  typedef struct packed {
    logic             wr;
    logic             rd;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [2:0]       exp_level;
    logic [WIDTH-1:0] exp_out;
    logic             exp_n_ovf;
    logic             exp_n_udf;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  initial begin
    // Fill, overflow, drain, underflow, simultaneous access on empty and full.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h61, 3'd1, 8'h61, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h62, 3'd2, 8'h61, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h63, 3'd3, 8'h61, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h64, 3'd4, 8'h61, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h65, 3'd4, 8'h61, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 8'h62, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 8'h63, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 8'h64, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h11, 3'd1, 8'h11, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h22, 3'd1, 8'h22, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h33, 3'd1, 8'h33, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h44, 3'd2, 8'h33, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h55, 3'd3, 8'h33, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h66, 3'd4, 8'h33, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 8'h77, 3'd4, 8'h44, 1'b1, 1'b1};

    n_rst = 1'b1; n_clr = 1'b1; n_wr = 1'b1; n_rd = 1'b1; port_in = '0;
    model_reset();

    // 1 ns reset pulse between edges; outputs must settle with no clock.
    #2 n_rst = 1'b0;
    #1 n_rst = 1'b1;
    chk("rst.level",    {29'd0, level}, 0);
    chk("rst.n_empty",  {31'd0, n_empty}, 0);
    chk("rst.n_full",   {31'd0, n_full}, 1);
    chk("rst.n_valid",  {31'd0, n_valid}, 1);
    chk("rst.n_aempty", {31'd0, n_aempty}, 0);
    chk("rst.n_afull",  {31'd0, n_afull}, 1);
    chk("rst.n_ovf",    {31'd0, n_ovf}, 1);
    chk("rst.n_udf",    {31'd0, n_udf}, 1);
    chk("rst.port_out", {24'd0, port_out}, 0);

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      chk($sformatf("vec%0d.level", i), {29'd0, level}, {29'd0, tbl[i].exp_level});
      chk($sformatf("vec%0d.out", i), {24'd0, port_out}, {24'd0, tbl[i].exp_out});
      chk($sformatf("vec%0d.n_ovf", i), {31'd0, n_ovf}, {31'd0, tbl[i].exp_n_ovf});
      chk($sformatf("vec%0d.n_udf", i), {31'd0, n_udf}, {31'd0, tbl[i].exp_n_udf});
    end

    // Wrap: ten write/read pairs, pointers go round the 4-entry ring twice.
    step("wrap.clr", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step("wrap.wr", 1'b1, 1'b0, 1'b0, 8'(i));
      chk($sformatf("wrap%0d.head", i), {24'd0, port_out}, i);
      step("wrap.rd", 1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("wrap%0d.level", i), {29'd0, level}, 0);
    end

    // Clear at level 3 with a sticky overflow and a competing write.
    for (int i = 0; i < 5; i++) step("clr.fill", 1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
    step("clr.rd", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("clr.pre_level", {29'd0, level}, 3);
    chk("clr.pre_n_ovf", {31'd0, n_ovf}, 0);
    n_wr = 1'b0;
    step("clr.hit", 1'b1, 1'b0, 1'b1, 8'hEE);
    chk("clr.level", {29'd0, level}, 0);
    chk("clr.n_empty", {31'd0, n_empty}, 0);
    chk("clr.n_ovf", {31'd0, n_ovf}, 1);
    step("clr.after", 1'b1, 1'b0, 1'b0, 8'h5A);
    chk("clr.discard", {24'd0, port_out}, 8'h5A);
    chk("clr.after_level", {29'd0, level}, 1);

    // Asynchronous reset mid-operation drops queued data without an edge.
    step("mid.wr", 1'b1, 1'b0, 1'b0, 8'hC1);
    step("mid.wr", 1'b1, 1'b0, 1'b0, 8'hC2);
    #2 n_rst = 1'b0;
    #1;
    chk("mid.level", {29'd0, level}, 0);
    chk("mid.port_out", {24'd0, port_out}, 0);
    chk("mid.n_empty", {31'd0, n_empty}, 0);
    #1 n_rst = 1'b1;
    model_reset();
    step("mid.first", 1'b1, 1'b1, 1'b0, 8'hD7);
    chk("mid.first_out", {24'd0, port_out}, 8'hD7);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      bit wr, rd, clr;
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 99) < 3);
      step("rand", wr, rd, clr, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wm.md
FIFO_WM -- requirements
Module: fifo_wm

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, number of storage entries (>=2, any integer, power of two not required).
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-005 Ports, in order:
- clk  in  1  sole clock, rising edge.
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low.
- n_clr  in  1  synchronous clear, active-low.
- n_wr  in  1  write request, active-low.
- n_rd  in  1  read/pop request, active-low.
- port_in  in  WIDTH  write data.
- port_out  out  WIDTH  head-of-queue data, first-word-fall-through.
- n_empty  out  1  low when level==0.
- n_full  out  1  low when level==DEPTH.
- n_valid  out  1  low when port_out holds valid data (level>0).
- n_aempty  out  1  low when level<=AE_LEVEL.
- n_afull  out  1  low when level>=AF_LEVEL.
- level  out  $clog2(DEPTH+1)  current entry count.
- n_ovf  out  1  sticky overflow error, active-low.
- n_udf  out  1  sticky underflow error, active-low.

Function
REQ-006 All state (rp, wp, level, storage, sticky flags) SHALL update only on rising clk; status outputs SHALL be combinational decodes of registered level.
REQ-007 Write SHALL be accepted when n_wr low and (level<DEPTH or a read is accepted in the same cycle); port_in is stored at wp and wp advances.
REQ-008 Read SHALL be accepted when n_rd low and level>0; rp advances and the next entry appears on port_out in the same cycle the edge completes (zero-cycle fall-through).
REQ-009 port_out SHALL equal storage[rp] when level>0 and SHALL be all-zero when level==0.
REQ-010 Simultaneous accepted read and write SHALL leave level unchanged.
REQ-011 Empty with n_wr and n_rd both low: only the write SHALL occur; level becomes 1.
REQ-012 Full with n_wr and n_rd both low: both SHALL occur; level stays DEPTH; n_ovf not set.
REQ-013 Write request rejected (full, no read) SHALL leave storage/level unchanged and set n_ovf low.
REQ-014 Read request while level==0 (including REQ-011 case) SHALL be ignored and set n_udf low.
REQ-015 rp and wp SHALL wrap from DEPTH-1 to 0 (modulo DEPTH, including non-power-of-two DEPTH).
REQ-016 n_ovf/n_udf SHALL stay low until reset or clear.
REQ-017 n_clr low at a rising edge SHALL zero rp, wp, level, release n_ovf/n_udf high, and override any write/read in that cycle.

Reset
REQ-018 n_rst low SHALL immediately force rp=wp=level=0, n_empty=0, n_full=1, n_valid=1, n_aempty=0, n_afull=1 (unless AF_LEVEL... n/a, AF_LEVEL>=1), n_ovf=1, n_udf=1, port_out=0; storage is not reset.
REQ-019 Reset asserted mid-operation SHALL discard all queued data; first edge after n_rst release SHALL behave as from empty.

Structure
REQ-020 Active-low constants nT (0) / nF (1) and the level-width function SHALL live in the shared common package, not in fifo_wm.
REQ-021 Pointer increment-with-wrap SHALL be one sub-module, fifo_ptr (params DEPTH; inputs clk, n_rst, n_clr, inc; output ptr), instantiated twice.
REQ-022 Target size 120-400 RTL lines; no vendor memory primitives.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-023 Reset: pulse n_rst low 1 ns -> level=0, n_empty=0, n_full=1, n_aempty=0, n_ovf=1, n_udf=1, port_out=8'h00.
REQ-024 Fill/overflow: write "a","b","c","d","e" on 5 edges -> level 1,2,3,4,4; n_afull low from level 3; n_full low at 4; n_ovf low after 5th; port_out="a" throughout.
REQ-025 Drain/underflow: from REQ-024, n_rd low 5 edges -> port_out "b","c","d",8'h00,8'h00; level 3,2,1,0,0; n_aempty low at level<=1; n_udf low after 5th.
REQ-026 Simultaneous r/w: empty + both low -> level=1, n_udf low; next edge both low -> level=1, port_out = second word; when full both low -> level=4, n_ovf stays 1.
REQ-027 Wrap: 10 write/read pairs, values 0..9, one at a time -> each value read in order, pointers wrap twice, level returns to 0.
REQ-028 Clear: level=3 with n_ovf low, n_clr low with n_wr low -> next edge level=0, n_empty=0, n_ovf=1, written word discarded.
